// File: rtl/rand_byte_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : rand_byte_gen_if
// Brief    : Valid/ready byte stream from rand_byte_gen to its consumer.
// Options  : RAND_BYTE_GEN_PARITY_EN adds rand_parity to the stream.
// Revision : 1.0 - initial release
// ============================================================================
interface rand_byte_gen_if;
    logic [7:0] rand_out;
    logic       rand_valid;
    logic       rand_ready;
`ifdef RAND_BYTE_GEN_PARITY_EN
    logic       rand_parity;

    modport master (
        output rand_out,
        output rand_valid,
        output rand_parity,
        input  rand_ready
    );

    modport slave (
        input  rand_out,
        input  rand_valid,
        input  rand_parity,
        output rand_ready
    );
`else
    modport master (
        output rand_out,
        output rand_valid,
        input  rand_ready
    );

    modport slave (
        input  rand_out,
        input  rand_valid,
        output rand_ready
    );
`endif
endinterface
`default_nettype wire

// File: rtl/rand_byte_gen.sv
`default_nettype none
// ============================================================================
// Module   : rand_byte_gen
// Brief    : 8-bit Fibonacci LFSR byte source with seed load, burst counter
//            and valid/ready output.
// Options  : RAND_BYTE_GEN_PARITY_EN adds even parity of rand_out.
// Revision : 1.0 - initial release
// ============================================================================
module rand_byte_gen #(
    parameter int         NUM_BYTES    = 10,
    parameter int         CNT_W        = 16,
    parameter logic [7:0] DEFAULT_SEED = 8'hA5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             start,
    input  wire logic             stop,
    input  wire logic             seed_load,
    input  wire logic [7:0]       seed,
    rand_byte_gen_if.master       rand_if,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      byte_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam bit               c_limited   = (NUM_BYTES != 0);
    localparam logic [CNT_W-1:0] c_num_bytes = CNT_W'(NUM_BYTES);

    state_t           state_q, state_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [7:0]       seed_reg_q, seed_reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             w_xfer;
    logic [7:0]       w_lfsr_next;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_xfer      = valid_q && rand_if.rand_ready;
    assign w_lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign w_cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        seed_reg_d = seed_reg_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A zero seed would lock the LFSR, so substitute the default.
                if (seed_load) begin
                    seed_reg_d = (seed == 8'h00) ? DEFAULT_SEED : seed;
                end
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                lfsr_d  = seed_reg_q;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (w_xfer) begin
                    lfsr_d = w_lfsr_next;
                    cnt_d  = w_cnt_inc;
                end
                if (w_xfer && c_limited && (w_cnt_inc == c_num_bytes)) begin
                    state_d = S_DONE;
                end else if (stop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered versions of the next state.
        valid_d = (state_d == S_RUN);
        busy_d  = (state_d == S_LOAD) || (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lfsr_q     <= DEFAULT_SEED;
            seed_reg_q <= DEFAULT_SEED;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            seed_reg_q <= seed_reg_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign rand_if.rand_out   = lfsr_q;
    assign rand_if.rand_valid = valid_q;
`ifdef RAND_BYTE_GEN_PARITY_EN
    assign rand_if.rand_parity = ^lfsr_q;
`endif
    assign busy       = busy_q;
    assign done       = done_q;
    assign byte_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rand_byte_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rand_byte_gen
// Brief    : Scoreboard bench for rand_byte_gen (limited and unlimited bursts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rand_byte_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_u, stop, seed_load, rand_ready;
    logic [7:0]  seed;
    logic        a_busy, a_done, u_busy, u_done;
    logic [15:0] a_cnt, u_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_u[$];

    rand_byte_gen_if a_if ();
    rand_byte_gen_if u_if ();
    assign a_if.rand_ready = rand_ready;
    assign u_if.rand_ready = rand_ready;

    rand_byte_gen #(.NUM_BYTES(10), .CNT_W(16), .DEFAULT_SEED(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop),
        .seed_load(seed_load), .seed(seed), .rand_if(a_if.master),
        .busy(a_busy), .done(a_done), .byte_count(a_cnt)
    );

    rand_byte_gen #(.NUM_BYTES(0), .CNT_W(16), .DEFAULT_SEED(8'hA5)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start_u), .stop(stop),
        .seed_load(seed_load), .seed(seed), .rand_if(u_if.master),
        .busy(u_busy), .done(u_done), .byte_count(u_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Hand-computed streams from seeds 01 and A5.
    logic [7:0] seq01 [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11,
                               8'h23, 8'h47, 8'h8E, 8'h1C, 8'h38};
    logic [7:0] seqa5 [10] = '{8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54,
                               8'hA9, 8'h53, 8'hA7, 8'h4E, 8'h9D};

    always @(negedge clk) begin
        if (a_if.rand_valid && a_if.rand_ready) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL a_unexpected_byte actual %02h required none", a_if.rand_out);
            end else begin
                logic [7:0] e;
                e = q_a.pop_front();
                if (a_if.rand_out !== e) begin
                    errors++;
                    $display("FAIL a_byte actual %02h required %02h", a_if.rand_out, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (u_if.rand_valid && u_if.rand_ready) begin
            checks++;
            if (q_u.size() == 0) begin
                errors++;
                $display("FAIL u_unexpected_byte actual %02h required none", u_if.rand_out);
            end else begin
                logic [7:0] e;
                e = q_u.pop_front();
                if (u_if.rand_out !== e || u_if.rand_out == 8'h00) begin
                    errors++;
                    $display("FAIL u_byte actual %02h required %02h", u_if.rand_out, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // All tasks enter and leave 1ns after a rising edge.
    task automatic load_seed(input logic [7:0] s);
        seed      = s;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    task automatic start_burst(input bit u);
        if (u) start_u = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_u = 1'b0;
        chk("load_busy",  u ? u_busy : a_busy, 1);
        chk("load_valid", u ? u_if.rand_valid : a_if.rand_valid, 0);
        @(posedge clk); #1;
        chk("run_valid",  u ? u_if.rand_valid : a_if.rand_valid, 1);
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk); #1;
            seen = a_done;
        end
        chk(nm, seen, 1);
    endtask

    task automatic push_a(input bit from01, input int n);
        for (int i = 0; i < n; i++) q_a.push_back(from01 ? seq01[i] : seqa5[i]);
    endtask

    initial begin
        rst_n = 1'b1; start_a = 1'b0; start_u = 1'b0; stop = 1'b0;
        seed_load = 1'b0; seed = 8'h00; rand_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rand_out", a_if.rand_out, 8'hA5);
        chk("rst_valid", a_if.rand_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_count", a_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Default seed burst to completion.
        push_a(0, 10);
        start_burst(0);
        wait_done("t1_done");
        chk("t1_busy", a_busy, 0);
        chk("t1_count", a_cnt, 10);
        chk("t1_valid", a_if.rand_valid, 0);

        // Seed 01 from DONE.
        load_seed(8'h01);
        push_a(1, 10);
        start_burst(0);
        wait_done("t2_done");
        chk("t2_count", a_cnt, 10);

        // Zero seed, unlimited instance, full period.
        load_seed(8'h00);
        begin
            logic [7:0] v;
            v = 8'hA5;
            for (int i = 0; i < 255; i++) begin
                q_u.push_back(v);
                v = lfsr_step(v);
            end
        end
        start_burst(1);
        repeat (255) @(posedge clk);
        #1;
        chk("t3_wrap_value", u_if.rand_out, 8'hA5);
        chk("t3_count", u_cnt, 255);
        chk("t3_still_valid", u_if.rand_valid, 1);
        rand_ready = 1'b0;
        stop       = 1'b1;
        @(posedge clk); #1;
        stop       = 1'b0;
        rand_ready = 1'b1;
        chk("t3_stop_busy", u_busy, 0);
        chk("t3_stop_valid", u_if.rand_valid, 0);
        chk("t3_stop_done", u_done, 0);

        // Backpressure 1,0,0,1.
        load_seed(8'h01);
        push_a(1, 10);
        start_burst(0);
        @(posedge clk); #1;
        rand_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_hold_out", a_if.rand_out, 8'h02);
            chk("t4_hold_count", a_cnt, 1);
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        rand_ready = 1'b1;
        wait_done("t4_done");
        chk("t4_count", a_cnt, 10);

        // Stop with same-cycle transfer; seed_load in RUN ignored.
        load_seed(8'h01);
        push_a(1, 4);
        start_burst(0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        stop      = 1'b1;
        seed_load = 1'b1;
        seed      = 8'h77;
        @(posedge clk); #1;
        stop      = 1'b0;
        seed_load = 1'b0;
        chk("t5_count", a_cnt, 4);
        chk("t5_busy", a_busy, 0);
        chk("t5_done", a_done, 0);
        chk("t5_valid", a_if.rand_valid, 0);
        push_a(1, 10);
        start_burst(0);
        wait_done("t5_restart_done");

        // Asynchronous reset mid-burst.
        push_a(1, 2);
        start_burst(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rand_out", a_if.rand_out, 8'hA5);
        chk("t6_valid", a_if.rand_valid, 0);
        chk("t6_busy", a_busy, 0);
        chk("t6_done", a_done, 0);
        chk("t6_count", a_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_a(0, 10);
        start_burst(0);
        wait_done("t6_restart_done");

        repeat (3) @(posedge clk);
        #1;
        chk("q_a_drained", q_a.size(), 0);
        chk("q_u_drained", q_u.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rand_byte_gen.md
Name: rand_byte_gen

Overview:
Upstream source for the random-data leg of the 2:1 byte mux: produces the 8-bit pseudo-random stream that the mux consumes on its random input. It uses an 8-bit maximal-length Fibonacci LFSR with a loadable seed and a burst counter. It has a valid/ready output handshake and a small FSM, so the stimulus/datapath can request a fixed-length burst and then pause or stop it.

Parameters:
NUM_BYTES, 10, bytes per burst; 0 = unlimited (runs until stop)
CNT_W, 16, width of transfer counter
DEFAULT_SEED, 8'hA5, seed used when the loaded seed is zero (LFSR lock-up guard)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin burst (honoured in IDLE or DONE)
stop  in  1  abort burst (honoured in RUN)
seed_load  in  1  capture seed into seed register (ignored in RUN/LOAD)
seed  in  8  seed value
rand_ready  in  1  consumer ready
rand_out  out  8  current LFSR value
rand_valid  out  1  rand_out valid
busy  out  1  high in LOAD or RUN
done  out  1  burst complete, level
byte_count  out  CNT_W  transfers completed in current burst

Behaviour:
- Reset (async, rst_n=0): state=IDLE, lfsr=DEFAULT_SEED, seed_reg=DEFAULT_SEED, byte_count=0, rand_valid=0, busy=0, done=0. rand_out=lfsr at all times.
- LFSR step: next = {lfsr[6:0], fb}, fb = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3] (x^8+x^6+x^5+x^4+1, period 255).
- seed_load in IDLE/DONE: seed_reg <= (seed==0) ? DEFAULT_SEED : seed. In LOAD/RUN it is ignored.
- FSM states IDLE, LOAD, RUN, DONE:
  - IDLE: start -> LOAD.
  - LOAD (1 cycle): lfsr <= seed_reg; byte_count <= 0; done <= 0; -> RUN.
  - RUN: rand_valid=1. A transfer is rand_valid && rand_ready; it advances lfsr and increments byte_count.
    - If a transfer makes byte_count equal NUM_BYTES (NUM_BYTES!=0): -> DONE, done<=1.
    - Else if stop: -> IDLE (a same-cycle transfer still completes and is counted).
  - DONE: rand_valid=0, done held. start -> LOAD (clears done). stop ignored.
- Latency: start sampled at edge N, LOAD during cycle N..N+1, rand_valid high from edge N+1. The first byte equals seed_reg.
- Backpressure: while rand_valid && !rand_ready, rand_out and byte_count are stable.
- start while in LOAD/RUN: ignored. start and stop in the same cycle in IDLE: start wins.
- byte_count wraps at 2^CNT_W in unlimited mode. byte_count holds its final value in DONE/IDLE until the next LOAD.
- rand_valid is a registered output: it falls on the edge leaving RUN and is never asserted in IDLE/LOAD/DONE.
- Reset mid-burst: immediate return to reset values; seed_reg also reverts to DEFAULT_SEED.

Optional Feature:
RAND_BYTE_GEN_PARITY_EN
- Defined: adds output rand_parity (1 bit) = ^rand_out (even parity over the byte), combinational from lfsr, valid whenever rand_valid.
- Undefined: port and logic absent; interface is exactly as listed above.

Test Plan:
1. Reset then start with no seed_load, rand_ready=1 -> bytes A5 first; 10 transfers, then done=1, busy=0, byte_count=10, rand_valid=0.
2. seed_load seed=8'h01, start, rand_ready=1 -> rand_out sequence 01,02,04,08,11,23,...; rand_valid rises 2 cycles after start.
3. seed_load seed=8'h00 -> first byte A5 (lock-up guard); rand_out never 00 over 255 transfers with NUM_BYTES=0 (period 255, returns to A5 at transfer 255).
4. Seed 01, toggle rand_ready 1,0,0,1 -> rand_out holds 02 across the stalled cycles, byte_count holds 1, no bytes skipped.
5. Seed 01, stop asserted with rand_ready=1 after 3 transfers -> same-cycle transfer counted (byte_count=4), state IDLE, done=0; seed_load while RUN is ignored.
6. rst_n pulsed low mid-burst -> all outputs at reset values immediately (asynchronously); the next start begins again at A5.
